input_pkt_tx: RTL

Downstream consumer of the 64-bit input-event FIFO written by the PS/2 and button interface. Pops event words, frames them into packets (header, up to MAX_EVENTS events sent as 8 bytes each, trailer), and streams the packets as bytes to the network transmit path over a valid/ready handshake. Packets close when they are full or after an idle timeout, so single keystrokes are not held back.

---
 rtl/input_pkt_defs_pkg.sv | 28 ++
 rtl/tx_byte_reg.sv | 54 +++++
 rtl/input_pkt_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/input_pkt_defs_pkg.sv
// Shared definitions for the input-event packetiser: framing constants,
// FSM state encoding and a byte-select helper for 64-bit event words.
package input_pkt_defs_pkg;

    localparam logic [7:0] PKT_MAGIC = 8'hE1;
    localparam int         HDR_LEN   = 2;
    localparam int         EVT_BYTES = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_POP,
        ST_LAT,
        ST_EVT,
        ST_GAP,
        ST_TRL,
        ST_CHK
    } state_t;

    // Returns byte idx of an event word, where idx 7 is bits [63:56].
    function automatic logic [7:0] evt_byte(input logic [63:0] word, input logic [2:0] idx);
        logic [63:0] shifted;
        shifted = word >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/tx_byte_reg.sv
// One-deep output register for the byte stream. A loaded byte is held on
// tx_d/valid/last until the sink accepts it; accept_out tells the FSM the
// handshake completed this cycle so it may load the next byte.
module tx_byte_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_in,
    input  logic [7:0] d_in,
    input  logic       last_in,
    input  logic       ready_in,
    output logic [7:0] tx_d_out,
    output logic       tx_valid_out,
    output logic       tx_last_out,
    output logic       accept_out
);

    logic [7:0] d_q, d_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;

    assign accept_out   = valid_q & ready_in;
    assign tx_d_out     = d_q;
    assign tx_valid_out = valid_q;
    assign tx_last_out  = last_q;

    // Load a new byte on request, otherwise drop valid once the byte is taken.
    always_comb begin
        d_d     = d_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_in) begin
            d_d     = d_in;
            valid_d = 1'b1;
            last_d  = last_in;
        end else if (accept_out) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q     <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/input_pkt_tx.sv
// Input-event packetiser: pops 64-bit event words from the input FIFO and
// streams them as packets (magic, seq, 8 bytes per event, trailer=count).
// A packet closes when MAX_EVENTS are in it or after TIMEOUT idle cycles.
// Optional macro INPUT_PKT_CHK_EN appends an XOR checksum byte that carries
// tx_last_out instead of the trailer.
module input_pkt_tx
    import input_pkt_defs_pkg::*;
#(
    parameter int MAX_EVENTS = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rd_en_out,
    input  logic [63:0] rd_d_in,
    input  logic        rd_empty_in,
    output logic [7:0]  tx_d_out,
    output logic        tx_valid_out,
    output logic        tx_last_out,
    input  logic        tx_ready_in,
    output logic [7:0]  seq_out
);

    localparam logic [7:0]  MAX_CNT    = 8'(MAX_EVENTS);
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);
`ifdef INPUT_PKT_CHK_EN
    localparam logic        TRL_LAST   = 1'b0;
`else
    localparam logic        TRL_LAST   = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] timer_q, timer_d;
    logic [63:0] evt_q, evt_d;
    logic [2:0]  rem_q, rem_d;
`ifdef INPUT_PKT_CHK_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic        load;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        accept;
    logic        go_trl;

    assign seq_out = seq_q;

    tx_byte_reg u_tx_byte_reg (
        .clk          (clk),
        .rst          (rst),
        .load_in      (load),
        .d_in         (load_byte),
        .last_in      (load_last),
        .ready_in     (tx_ready_in),
        .tx_d_out     (tx_d_out),
        .tx_valid_out (tx_valid_out),
        .tx_last_out  (tx_last_out),
        .accept_out   (accept)
    );

    // Next-state logic: each sending state moves on only after its byte is accepted.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        count_d   = count_q;
        timer_d   = timer_q;
        evt_d     = evt_q;
        rem_d     = rem_q;
        load      = 1'b0;
        load_byte = 8'h00;
        load_last = 1'b0;
        rd_en_out = 1'b0;
        go_trl    = 1'b0;
`ifdef INPUT_PKT_CHK_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rd_empty_in) begin
                    load      = 1'b1;
                    load_byte = PKT_MAGIC;
                    state_d   = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (accept) begin
                    load      = 1'b1;
                    load_byte = seq_q;
                    state_d   = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                if (!rd_empty_in) begin
                    rd_en_out = 1'b1;
                    state_d   = ST_LAT;
                end
            end
            ST_LAT: begin
                evt_d     = rd_d_in;
                load      = 1'b1;
                load_byte = rd_d_in[63:56];
                rem_d     = 3'(EVT_BYTES - 1);
                state_d   = ST_EVT;
            end
            ST_EVT: begin
                if (accept) begin
                    if (rem_q == 3'd0) begin
                        count_d = count_q + 8'd1;
                        timer_d = 32'd0;
                        state_d = ST_GAP;
                    end else begin
                        load      = 1'b1;
                        load_byte = evt_byte(evt_q, rem_q - 3'd1);
                        rem_d     = rem_q - 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (count_q == MAX_CNT) begin
                    go_trl = 1'b1;
                end else if (!rd_empty_in) begin
                    timer_d = 32'd0;
                    state_d = ST_POP;
                end else if (timer_q == TIMER_LAST) begin
                    go_trl = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
                if (go_trl) begin
                    load      = 1'b1;
                    load_byte = count_q;
                    load_last = TRL_LAST;
                    state_d   = ST_TRL;
                end
            end
            ST_TRL: begin
                if (accept) begin
`ifdef INPUT_PKT_CHK_EN
                    load      = 1'b1;
                    load_byte = chk_q;
                    load_last = 1'b1;
                    state_d   = ST_CHK;
`else
                    seq_d   = seq_q + 8'd1;
                    count_d = 8'd0;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef INPUT_PKT_CHK_EN
            ST_CHK: begin
                if (accept) begin
                    seq_d   = seq_q + 8'd1;
                    count_d = 8'd0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef INPUT_PKT_CHK_EN
        if (load && (state_q != ST_TRL)) begin
            chk_d = (state_q == ST_IDLE) ? load_byte : (chk_q ^ load_byte);
        end
`endif
    end

    // State, counters and captured event word with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seq_q   <= 8'h00;
            count_q <= 8'h00;
            timer_q <= 32'd0;
            evt_q   <= 64'd0;
            rem_q   <= 3'd0;
`ifdef INPUT_PKT_CHK_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            count_q <= count_d;
            timer_q <= timer_d;
            evt_q   <= evt_d;
            rem_q   <= rem_d;
`ifdef INPUT_PKT_CHK_EN
            chk_q   <= chk_d;
`endif
        end
    end

endmodule
